// File: rtl/otter_ex_mem_reg.sv
// otter_ex_mem_reg: EX->MEM pipeline register of the pipelined OTTER.
//
// Registers the execute-stage results (ALU result, store data, PC+4, rd and
// the MEM/WB controls) into the MEM stage. It also resolves branches and jumps
// in EX and raises PCSrcE so that fetch can redirect to PCTargetE.
//
// Optional build macro: OTTER_EXMEM_FWD_EN
//   When it is defined, the block adds the inputs Rs1E and Rs2E and the
//   combinational outputs ForwardAM and ForwardBM. These flag that the
//   instruction in MEM produces a source operand of the instruction in EX.
//   When it is undefined, those ports are absent and the external hazard unit
//   does all forwarding.
//
// Stage qualification:
//   ValidE / ValidM mark a real instruction in EX / MEM. There is no
//   back-pressure handshake. On every rising edge the stage does exactly one
//   of the following, in priority order:
//     1. RST    : the stage is cleared to zero.
//     2. FlushM : a bubble is loaded (every registered output is zero).
//     3. StallM : every register holds its value.
//     4. capture: the stage takes the E fields if ValidE=1, and loads a
//                 bubble if ValidE=0.
//   PCSrcE is asserted only in the cycle in which the instruction actually
//   advances, that is, with ValidE=1, StallM=0 and RST=0.

module otter_ex_mem_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              ValidE,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic              ZeroE,
    input  logic [XLEN-1:0]   WriteDataE,
    input  logic [XLEN-1:0]   PCTargetE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              BranchE,
    input  logic              BranchNeE,
    input  logic              JumpE,
`ifdef OTTER_EXMEM_FWD_EN
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    output logic              ForwardAM,
    output logic              ForwardBM,
`endif
    output logic              PCSrcE,
    output logic              ValidM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM
);

    // MEM-stage state
    logic              valid_q,        valid_d;
    logic [XLEN-1:0]   alu_result_q,   alu_result_d;
    logic [XLEN-1:0]   write_data_q,   write_data_d;
    logic [XLEN-1:0]   pc_plus4_q,     pc_plus4_d;
    logic [REG_AW-1:0] rd_q,           rd_d;
    logic              reg_write_q,    reg_write_d;
    logic              mem_write_q,    mem_write_d;
    logic [1:0]        result_src_q,   result_src_d;

    // Per-edge action decode
    logic load_bubble;
    logic capture;
    logic taken;

    // PCTargetE is routed straight to fetch by the datapath. It is listed here
    // only so that this block presents the full EX bundle.
    logic unused_pc_target;
    assign unused_pc_target = ^PCTargetE;

    // A flush always wins. An idle EX slot that advances also becomes a bubble.
    assign load_bubble = FlushM | (~StallM & ~ValidE);
    assign capture     = ~FlushM & ~StallM & ValidE;

    // Branch resolution. The ALU runs SUB for branches, so ZeroE means rs1==rs2.
    // BEQ is taken on ZeroE and BNE is taken on !ZeroE.
    assign taken  = JumpE | (BranchE & (ZeroE ^ BranchNeE));
    assign PCSrcE = ValidE & ~StallM & ~RST & taken;

    // Next-state selection: hold by default, then bubble or capture
    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_plus4_d   = pc_plus4_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        result_src_d = result_src_q;
        if (load_bubble) begin
            valid_d      = 1'b0;
            alu_result_d = '0;
            write_data_d = '0;
            pc_plus4_d   = '0;
            rd_d         = '0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = 2'b00;
        end else if (capture) begin
            valid_d      = 1'b1;
            alu_result_d = ALUResultE;
            write_data_d = WriteDataE;
            pc_plus4_d   = PCPlus4E;
            rd_d         = RdE;
            reg_write_d  = RegWriteE;
            mem_write_d  = MemWriteE;
            result_src_d = ResultSrcE;
        end
    end

    // MEM-stage registers with synchronous clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
        end else begin
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
        end
    end

    // Write enables are qualified by ValidM, so a bubble can never write
    assign ValidM     = valid_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;
    assign RegWriteM  = valid_q & reg_write_q;
    assign MemWriteM  = valid_q & mem_write_q;
    assign ResultSrcM = result_src_q;

`ifdef OTTER_EXMEM_FWD_EN
    // MEM result feeds an EX source operand; x0 is never forwarded
    assign ForwardAM = ValidM & RegWriteM & (RdM != '0) & (RdM == Rs1E);
    assign ForwardBM = ValidM & RegWriteM & (RdM != '0) & (RdM == Rs2E);
`endif

endmodule

// File: tb/tb_otter_ex_mem_reg.sv
// tb_otter_ex_mem_reg: randomized scoreboard bench for otter_ex_mem_reg.
// With OTTER_EXMEM_FWD_EN defined, the forwarding outputs are checked as well.

module tb_otter_ex_mem_reg;

    localparam int MW = 106;          // packed MEM-stage view width
    localparam int EW = MW + 3;       // {pcsrc, fwd_a, fwd_b, mem}

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, StallM, FlushM, ValidE, ZeroE;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  Rs1E, Rs2E;
    logic        ForwardAM, ForwardBM;
    logic        PCSrcE, ValidM, RegWriteM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;

    otter_ex_mem_reg #(.XLEN(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST), .StallM(StallM), .FlushM(FlushM), .ValidE(ValidE),
        .ALUResultE(ALUResultE), .ZeroE(ZeroE), .WriteDataE(WriteDataE),
        .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE),
`ifdef OTTER_EXMEM_FWD_EN
        .Rs1E(Rs1E), .Rs2E(Rs2E), .ForwardAM(ForwardAM), .ForwardBM(ForwardBM),
`endif
        .PCSrcE(PCSrcE), .ValidM(ValidM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

`ifndef OTTER_EXMEM_FWD_EN
    assign ForwardAM = 1'b0;
    assign ForwardBM = 1'b0;
`endif

    // ---------------- stimulus / model types ----------------
    typedef struct {
        logic        rst, stall, flush, valid, zero;
        logic [31:0] alu, wd, tgt, pc4;
        logic [4:0]  rd, rs1, rs2;
        logic        rw, mw, br, bne, jmp;
        logic [1:0]  rsrc;
    } ex_in_t;

    typedef struct {
        logic        valid;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rsrc;
    } mem_t;

    ex_in_t cur;
    mem_t   m_model;
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic ex_in_t blank_in();
        ex_in_t e;
        e.rst = 0; e.stall = 0; e.flush = 0; e.valid = 0; e.zero = 0;
        e.alu = 0; e.wd = 0; e.tgt = 0; e.pc4 = 0;
        e.rd = 0; e.rs1 = 0; e.rs2 = 0;
        e.rw = 0; e.mw = 0; e.br = 0; e.bne = 0; e.jmp = 0; e.rsrc = 0;
        return e;
    endfunction

    function automatic mem_t empty_stage();
        mem_t m;
        m.valid = 0; m.alu = 0; m.wd = 0; m.pc4 = 0;
        m.rd = 0; m.rw = 0; m.mw = 0; m.rsrc = 0;
        return m;
    endfunction

    // ---------------- reference model ----------------
    // The MEM stage is what EX handed over at the last edge on which it
    // advanced. Reset, a flush, or an empty EX slot leave it empty; a stall
    // leaves it as it was.
    function automatic mem_t next_stage(input mem_t m, input ex_in_t e);
        mem_t n;
        if (e.rst || e.flush) return empty_stage();
        if (e.stall) return m;
        if (!e.valid) return empty_stage();
        n.valid = 1; n.alu = e.alu; n.wd = e.wd; n.pc4 = e.pc4;
        n.rd = e.rd; n.rw = e.rw; n.mw = e.mw; n.rsrc = e.rsrc;
        return n;
    endfunction

    // Redirect happens only for a real instruction that advances this cycle:
    // jumps always, BEQ when operands are equal, BNE when they differ.
    function automatic logic redirect(input ex_in_t e);
        if (e.rst || e.stall || !e.valid) return 1'b0;
        if (e.jmp) return 1'b1;
        if (e.br) return e.bne ? !e.zero : e.zero;
        return 1'b0;
    endfunction

    function automatic logic fwd(input mem_t m, input logic [4:0] rs);
        return m.valid && m.rw && (m.rd != 0) && (m.rd == rs);
    endfunction

    function automatic logic [MW-1:0] pack_stage(input mem_t m);
        return {m.valid, m.alu, m.wd, m.pc4, m.rd, m.valid & m.rw, m.valid & m.mw, m.rsrc};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input ex_in_t e);
        RST = e.rst; StallM = e.stall; FlushM = e.flush; ValidE = e.valid;
        ALUResultE = e.alu; ZeroE = e.zero; WriteDataE = e.wd; PCTargetE = e.tgt;
        PCPlus4E = e.pc4; RdE = e.rd; Rs1E = e.rs1; Rs2E = e.rs2;
        RegWriteE = e.rw; MemWriteE = e.mw; ResultSrcE = e.rsrc;
        BranchE = e.br; BranchNeE = e.bne; JumpE = e.jmp;
    endtask

    // One cycle: let the edge consume cur, update the model, present the next
    // inputs, and queue what the monitor must see during this cycle.
    task automatic step(input ex_in_t nxt);
        @(posedge CLK);
        #1;
        m_model = next_stage(m_model, cur);
        cur = nxt;
        drive(cur);
        exp_q.push_back({redirect(cur), fwd(m_model, cur.rs1), fwd(m_model, cur.rs2),
                         pack_stage(m_model)});
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic ex_in_t rand_in();
        ex_in_t e = blank_in();
        int sel;
        e.rst   = ($urandom_range(0, 40) == 0);
        e.stall = ($urandom_range(0, 4) == 0);
        e.flush = ($urandom_range(0, 7) == 0);
        e.valid = ($urandom_range(0, 5) != 0);
        sel = $urandom_range(0, 5);
        e.alu = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hDEADDEAD : $urandom;
        e.zero = (e.alu == 32'h0);
        e.wd  = $urandom;
        e.tgt = $urandom;
        e.pc4 = $urandom & 32'hFFFF_FFFC;
        e.rd  = 5'($urandom_range(0, 31));
        e.rs1 = $urandom_range(0, 1) ? m_model.rd : 5'($urandom_range(0, 31));
        e.rs2 = $urandom_range(0, 1) ? m_model.rd : 5'($urandom_range(0, 31));
        e.rw  = 1'($urandom_range(0, 1));
        e.mw  = 1'($urandom_range(0, 1));
        e.rsrc = 2'($urandom_range(0, 2));
        e.br  = 1'($urandom_range(0, 1));
        e.bne = 1'($urandom_range(0, 1));
        e.jmp = ($urandom_range(0, 5) == 0);
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        logic [MW-1:0] act_m;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_m = {ValidM, ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
            total++;
            if (act_m !== e[MW-1:0]) begin
                bad++;
                $display("FAIL mem_stage got=%h want=%h", act_m, e[MW-1:0]);
            end
            total++;
            if (PCSrcE !== e[EW-1]) begin
                bad++;
                $display("FAIL pcsrc got=%b want=%b", PCSrcE, e[EW-1]);
            end
`ifdef OTTER_EXMEM_FWD_EN
            total++;
            if ({ForwardAM, ForwardBM} !== e[EW-2:EW-3]) begin
                bad++;
                $display("FAIL forward got=%b want=%b", {ForwardAM, ForwardBM}, e[EW-2:EW-3]);
            end
`endif
            total++;
            if (!ValidM && (RegWriteM || MemWriteM)) begin
                bad++;
                $display("FAIL we_invariant got=%b%b want=00", RegWriteM, MemWriteM);
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        ex_in_t e;
        m_model = empty_stage();
        cur = blank_in();
        cur.rst = 1;
        drive(cur);

        // Reset asserted while every E input is nonzero.
        e = blank_in();
        e.rst = 1; e.stall = 1; e.valid = 1; e.zero = 1; e.alu = 32'hFFFF_FFFF;
        e.wd = 32'h1111_1111; e.tgt = 32'h2222_2222; e.pc4 = 32'h3333_3334;
        e.rd = 5'd31; e.rs1 = 5'd31; e.rs2 = 5'd31; e.rw = 1; e.mw = 1; e.rsrc = 2'b10;
        e.br = 1; e.bne = 1; e.jmp = 1;
        step(e);
        #1 lit("rst_pcsrc", {31'b0, PCSrcE}, 32'd0);

        // Capture of a plain ALU op.
        e = blank_in();
        e.valid = 1; e.alu = 32'h0000_1234; e.rd = 5'd5; e.rw = 1;
        step(e);
        #1;
        lit("rst_validm", {31'b0, ValidM}, 32'd0);
        lit("rst_alum", ALUResultM, 32'd0);
        lit("rst_regwm", {31'b0, RegWriteM}, 32'd0);

        // BEQ with equal operands is taken in the same cycle.
        e = blank_in();
        e.valid = 1; e.br = 1; e.bne = 0; e.zero = 1;
        step(e);
        #1;
        lit("cap_alum", ALUResultM, 32'h0000_1234);
        lit("cap_rdm", {27'b0, RdM}, 32'd5);
        lit("cap_regwm", {31'b0, RegWriteM}, 32'd1);
        lit("cap_validm", {31'b0, ValidM}, 32'd1);
        lit("beq_taken", {31'b0, PCSrcE}, 32'd1);

        // BNE with equal operands is not taken.
        e.bne = 1;
        step(e);
        #1 lit("bne_not_taken", {31'b0, PCSrcE}, 32'd0);

        // Load A5A5A5A5, then stall three cycles with new data and a jump.
        e = blank_in();
        e.valid = 1; e.alu = 32'hA5A5_A5A5; e.rd = 5'd9; e.rw = 1;
        step(e);
        for (int i = 0; i < 3; i++) begin
            e = blank_in();
            e.valid = 1; e.stall = 1; e.jmp = 1; e.alu = $urandom; e.rd = 5'd3; e.rw = 1;
            step(e);
            #1 lit("stall_pcsrc", {31'b0, PCSrcE}, 32'd0);
        end
        e = blank_in();
        e.valid = 1; e.stall = 1; e.flush = 1; e.rw = 1; e.mw = 1; e.alu = 32'h77;
        step(e);
        #1 lit("stall_hold_alum", ALUResultM, 32'hA5A5_A5A5);
        e = blank_in();
        step(e);
        #1;
        lit("flush_validm", {31'b0, ValidM}, 32'd0);
        lit("flush_regwm", {31'b0, RegWriteM}, 32'd0);
        lit("flush_memwm", {31'b0, MemWriteM}, 32'd0);

`ifdef OTTER_EXMEM_FWD_EN
        e = blank_in();
        e.valid = 1; e.rd = 5'd7; e.rw = 1;
        step(e);
        e = blank_in();
        e.rs1 = 5'd7; e.rs2 = 5'd0;
        step(e);
        #1;
        lit("fwd_a_hit", {31'b0, ForwardAM}, 32'd1);
        lit("fwd_b_x0", {31'b0, ForwardBM}, 32'd0);
        e = blank_in();
        e.valid = 1; e.rd = 5'd0; e.rw = 1;
        step(e);
        e = blank_in();
        e.rs1 = 5'd0;
        step(e);
        #1 lit("fwd_a_rd0", {31'b0, ForwardAM}, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) step(rand_in());
        step(blank_in());
        @(negedge CLK);
        #1;
        lit("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
